refill_tid_arbiter: RTL and testbench
=====================================

Name: refill_tid_arbiter

Overview:
- Shares the single cache-refill memory request channel between NrPorts requesters (port 0 = icache miss, port 1 = dcache miss/uncached).
- Round-robin arbitration; remaps each requester's local transaction ID onto a pool of 2^MemTidWidth memory-side TIDs.
- Routes each single-beat response back to the issuing port with its original ID.
- Sits between the cache subsystem and the NoC adapter; NoC adapter sees unique TIDs only.

Parameters:
- NrPorts, 2, number of requesters (2..4)
- PortTidWidth, 3, requester-local TID width (matches DcacheIdWidth)
- MemTidWidth, 4, memory-side TID width; pool size = 2^MemTidWidth
- ReqDataWidth, 128, request payload width (address + attributes, opaque)
- RspDataWidth, 128, response payload width (one cache line)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NrPorts  per-port request valid
- req_ready_o  out  NrPorts  per-port request accepted
- req_tid_i  in  NrPorts*PortTidWidth  per-port local TID
- req_data_i  in  NrPorts*ReqDataWidth  per-port request payload
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory request accepted
- mem_req_tid_o  out  MemTidWidth  allocated memory TID
- mem_req_data_o  out  ReqDataWidth  forwarded payload
- mem_rsp_valid_i  in  1  memory response valid (always accepted)
- mem_rsp_tid_i  in  MemTidWidth  response TID
- mem_rsp_data_i  in  RspDataWidth  response payload
- rsp_valid_o  out  NrPorts  one-hot response strobe
- rsp_tid_o  out  PortTidWidth  original local TID of response
- rsp_data_o  out  RspDataWidth  mem_rsp_data_i passthrough
- busy_o  out  1  any TID outstanding
- spurious_o  out  1  one-cycle pulse: response to unallocated TID

Behaviour:
- Reset (rst_ni=0, async): all TIDs free, rr pointer = 0, lock cleared; all outputs 0 (combinational outputs 0 because valid-table empty and no lock).
- State per memory TID: valid bit, owner port (clog2(NrPorts)), local TID. Plus rr pointer, lock flag, locked port.
- Arbitration: zero-cycle; if a free TID exists and no lock, grant = first requesting port at or after rr pointer (mod NrPorts). mem_req_* driven from granted port; mem_req_tid_o = lowest-index free TID.
- Pool empty (all valid): mem_req_valid_o=0, all req_ready_o=0.
- Lock: if mem_req_valid_o=1 and mem_req_ready_i=0, grant and chosen TID frozen until handshake; requesters must hold valid/data stable (AXI rules). Other ports ignored meanwhile.
- Handshake (mem_req_valid_o & mem_req_ready_i): req_ready_o[grant]=1 same cycle; table[tid] <= {1, grant, req_tid}; rr <= grant+1 mod NrPorts; lock cleared.
- Response: mem_rsp_valid_i with table[tid].valid -> rsp_valid_o[owner]=1, rsp_tid_o=local TID, same cycle (combinational); entry freed at clock edge.
- Response to invalid entry: no rsp_valid_o, spurious_o=1 for that cycle, table unchanged.
- Same-cycle free and allocate: freed TID not reusable until the next cycle; allocation picks among TIDs free at cycle start.
- Multiple outstanding TIDs per port allowed; duplicate local TIDs from one port allowed (kept distinct by memory TID).
- busy_o = OR of valid bits (registered state, combinational OR).
- Reset mid-operation: table cleared; later responses for old TIDs flagged spurious.

Optional Feature:
- CVA6_REFILL_ARB_STATS_EN defined: per-port 32-bit saturating stall counters (cycles req_valid_i=1 & req_ready_o=0), output stall_cnt_o (NrPorts*32), cleared by reset.
- Undefined: no counters, no stall_cnt_o port.

Decomposition:
- Shared package: tid table entry struct (valid, owner, local tid), PortIdxWidth = clog2(NrPorts), pool size constant.
- One sub-module: refill_tid_pool (free-list: lowest-free find, alloc/free, full/busy); arbiter/lock/routing stays in top.

Test Plan:
- Port 0 and 1 request at once after reset, ready=1 -> port 0 granted, mem TID 0; next cycle port 1 granted, mem TID 1; rr alternates.
- Port 1 sends local TID 5, response on mem TID 0 with data 0xA5.. -> rsp_valid_o=2'b10, rsp_tid_o=5, rsp_data_o=0xA5.., busy_o falls.
- Issue 16 requests without responses -> 17th stalls (ready=0); response on TID 7 -> next cycle new request gets TID 7.
- mem_req_ready_i=0 for 3 cycles while port 0 granted and port 1 raises valid -> grant/TID stable 3 cycles, port 0 accepted on cycle 4.
- mem_rsp_valid_i with TID 9 never allocated -> spurious_o pulses 1 cycle, no rsp_valid_o.
- Assert rst_ni low with 4 outstanding -> busy_o=0 immediately; old TID 2 response afterwards -> spurious_o=1.

Source files
------------

// File: rtl/refill_tid_arbiter_pkg.sv
// Shared types and sizing for the refill TID arbiter and its TID pool.
package refill_tid_arbiter_pkg;

    localparam int unsigned NrPorts      = 2;
    localparam int unsigned PortTidWidth = 3;
    localparam int unsigned MemTidWidth  = 4;
    localparam int unsigned ReqDataWidth = 128;
    localparam int unsigned RspDataWidth = 128;
    localparam int unsigned PoolSize     = 1 << MemTidWidth;
    localparam int unsigned PortIdxWidth = $clog2(NrPorts);
    localparam int unsigned StallCntWidth = 32;

    typedef struct packed {
        logic                    valid;
        logic [PortIdxWidth-1:0] owner;
        logic [PortTidWidth-1:0] local_tid;
    } tid_entry_t;

endpackage

// File: rtl/refill_tid_pool.sv
// Memory-side TID table: lowest-free search, allocate/free and response lookup.
module refill_tid_pool
    import refill_tid_arbiter_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   alloc_i,
    input  logic [MemTidWidth-1:0] alloc_tid_i,
    input  tid_entry_t             alloc_entry_i,
    input  logic                   free_i,
    input  logic [MemTidWidth-1:0] free_tid_i,
    input  logic [MemTidWidth-1:0] lookup_tid_i,
    output tid_entry_t             lookup_entry_o,
    output logic [MemTidWidth-1:0] free_tid_o,
    output logic                   full_o,
    output logic                   busy_o
);

    tid_entry_t table_q [PoolSize];

    // Allocation and free never hit the same TID: allocation only picks TIDs free at cycle start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(PoolSize); i++) begin
                table_q[i] <= '0;
            end
        end else begin
            if (free_i) begin
                table_q[free_tid_i].valid <= 1'b0;
            end
            if (alloc_i) begin
                table_q[alloc_tid_i] <= alloc_entry_i;
            end
        end
    end

    always_comb begin
        logic found;
        found      = 1'b0;
        free_tid_o = '0;
        full_o     = 1'b1;
        busy_o     = 1'b0;
        for (int i = 0; i < int'(PoolSize); i++) begin
            if (!table_q[i].valid && !found) begin
                free_tid_o = MemTidWidth'(i);
                found      = 1'b1;
            end
            full_o = full_o & table_q[i].valid;
            busy_o = busy_o | table_q[i].valid;
        end
    end

    assign lookup_entry_o = table_q[lookup_tid_i];

endmodule

// File: rtl/refill_tid_arbiter.sv
// Round-robin refill request arbiter with memory-side TID remapping and response routing.
// Optional per-port stall counters when CVA6_REFILL_ARB_STATS_EN is defined.
module refill_tid_arbiter
    import refill_tid_arbiter_pkg::*;
(
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrPorts-1:0]                req_valid_i,
    output logic [NrPorts-1:0]                req_ready_o,
    input  logic [NrPorts*PortTidWidth-1:0]   req_tid_i,
    input  logic [NrPorts*ReqDataWidth-1:0]   req_data_i,
    output logic                              mem_req_valid_o,
    input  logic                              mem_req_ready_i,
    output logic [MemTidWidth-1:0]            mem_req_tid_o,
    output logic [ReqDataWidth-1:0]           mem_req_data_o,
    input  logic                              mem_rsp_valid_i,
    input  logic [MemTidWidth-1:0]            mem_rsp_tid_i,
    input  logic [RspDataWidth-1:0]           mem_rsp_data_i,
    output logic [NrPorts-1:0]                rsp_valid_o,
    output logic [PortTidWidth-1:0]           rsp_tid_o,
    output logic [RspDataWidth-1:0]           rsp_data_o,
`ifdef CVA6_REFILL_ARB_STATS_EN
    output logic [NrPorts*StallCntWidth-1:0]  stall_cnt_o,
`endif
    output logic                              busy_o,
    output logic                              spurious_o
);

    logic [PortIdxWidth-1:0] rr_q;
    logic                    lock_q;
    logic [PortIdxWidth-1:0] lock_port_q;
    logic [MemTidWidth-1:0]  lock_tid_q;

    logic [PortIdxWidth-1:0] grant;
    logic                    grant_valid;
    logic [MemTidWidth-1:0]  tid_sel;
    logic                    handshake;
    logic [MemTidWidth-1:0]  pool_free_tid;
    logic                    pool_full;
    tid_entry_t              alloc_entry;
    tid_entry_t              rsp_entry;
    logic                    rsp_hit;

    refill_tid_pool u_pool (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .alloc_i        (handshake),
        .alloc_tid_i    (tid_sel),
        .alloc_entry_i  (alloc_entry),
        .free_i         (rsp_hit),
        .free_tid_i     (mem_rsp_tid_i),
        .lookup_tid_i   (mem_rsp_tid_i),
        .lookup_entry_o (rsp_entry),
        .free_tid_o     (pool_free_tid),
        .full_o         (pool_full),
        .busy_o         (busy_o)
    );

    // A stalled request keeps its grant and TID until the memory side accepts it.
    always_comb begin
        logic found;
        int unsigned idx;
        found       = 1'b0;
        idx         = 0;
        grant       = lock_port_q;
        grant_valid = 1'b0;
        if (lock_q) begin
            grant_valid = req_valid_i[lock_port_q];
        end else if (!pool_full) begin
            for (int unsigned i = 0; i < NrPorts; i++) begin
                idx = (32'(rr_q) + i) % NrPorts;
                if (!found && req_valid_i[idx]) begin
                    grant = PortIdxWidth'(idx);
                    found = 1'b1;
                end
            end
            grant_valid = found;
        end
    end

    assign tid_sel         = lock_q ? lock_tid_q : pool_free_tid;
    assign handshake       = grant_valid & mem_req_ready_i;
    assign mem_req_valid_o = grant_valid;
    assign mem_req_tid_o   = grant_valid ? tid_sel : '0;
    assign mem_req_data_o  = grant_valid ? req_data_i[32'(grant)*ReqDataWidth +: ReqDataWidth] : '0;
    assign req_ready_o     = handshake ? (NrPorts'(1) << grant) : '0;

    assign alloc_entry.valid     = 1'b1;
    assign alloc_entry.owner     = grant;
    assign alloc_entry.local_tid = req_tid_i[32'(grant)*PortTidWidth +: PortTidWidth];

    assign rsp_hit     = mem_rsp_valid_i & rsp_entry.valid;
    assign rsp_valid_o = rsp_hit ? (NrPorts'(1) << rsp_entry.owner) : '0;
    assign rsp_tid_o   = rsp_hit ? rsp_entry.local_tid : '0;
    assign rsp_data_o  = mem_rsp_data_i;
    assign spurious_o  = mem_rsp_valid_i & ~rsp_entry.valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= '0;
            lock_q      <= 1'b0;
            lock_port_q <= '0;
            lock_tid_q  <= '0;
        end else begin
            lock_q      <= grant_valid & ~mem_req_ready_i;
            lock_port_q <= grant;
            lock_tid_q  <= tid_sel;
            if (handshake) begin
                rr_q <= (32'(grant) == NrPorts - 1) ? '0 : grant + PortIdxWidth'(1);
            end
        end
    end

`ifdef CVA6_REFILL_ARB_STATS_EN
    logic [StallCntWidth-1:0] stall_q [NrPorts];

    // Saturating count of cycles each port waits with a pending request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrPorts); i++) begin
                stall_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NrPorts); i++) begin
                if (req_valid_i[i] && !req_ready_o[i] && (stall_q[i] != '1)) begin
                    stall_q[i] <= stall_q[i] + StallCntWidth'(1);
                end
            end
        end
    end

    always_comb begin
        stall_cnt_o = '0;
        for (int i = 0; i < int'(NrPorts); i++) begin
            stall_cnt_o[i*StallCntWidth +: StallCntWidth] = stall_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_refill_tid_arbiter.sv
// Directed self-checking bench for refill_tid_arbiter.
module tb_refill_tid_arbiter;
    import refill_tid_arbiter_pkg::*;

    logic                            clk;
    logic                            rst_n;
    logic [NrPorts-1:0]              req_valid;
    logic [NrPorts-1:0]              req_ready;
    logic [NrPorts*PortTidWidth-1:0] req_tid;
    logic [NrPorts*ReqDataWidth-1:0] req_data;
    logic                            mem_req_valid;
    logic                            mem_req_ready;
    logic [MemTidWidth-1:0]          mem_req_tid;
    logic [ReqDataWidth-1:0]         mem_req_data;
    logic                            mem_rsp_valid;
    logic [MemTidWidth-1:0]          mem_rsp_tid;
    logic [RspDataWidth-1:0]         mem_rsp_data;
    logic [NrPorts-1:0]              rsp_valid;
    logic [PortTidWidth-1:0]         rsp_tid;
    logic [RspDataWidth-1:0]         rsp_data;
    logic                            busy;
    logic                            spurious;
`ifdef CVA6_REFILL_ARB_STATS_EN
    logic [NrPorts*StallCntWidth-1:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [ReqDataWidth-1:0] D0 = {4{32'h0000_1111}};
    localparam logic [ReqDataWidth-1:0] D1 = {4{32'h2222_0000}};
    localparam logic [RspDataWidth-1:0] DA = {16{8'hA5}};

    refill_tid_arbiter dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_tid_i       (req_tid),
        .req_data_i      (req_data),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_tid_o   (mem_req_tid),
        .mem_req_data_o  (mem_req_data),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_tid_i   (mem_rsp_tid),
        .mem_rsp_data_i  (mem_rsp_data),
        .rsp_valid_o     (rsp_valid),
        .rsp_tid_o       (rsp_tid),
        .rsp_data_o      (rsp_data),
`ifdef CVA6_REFILL_ARB_STATS_EN
        .stall_cnt_o     (stall_cnt),
`endif
        .busy_o          (busy),
        .spurious_o      (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        req_tid       = '0;
        req_data      = {D1, D0};
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_tid   = '0;
        mem_rsp_data  = '0;
        #12;
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_mem_valid", 128'(mem_req_valid), 128'(0));
        check_eq("rst_ready", 128'(req_ready), 128'(0));
        check_eq("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check_eq("rst_spurious", 128'(spurious), 128'(0));
        rst_n = 1'b1;
        tick();

        // Both ports request: port 0 first, then port 1, then port 0 again.
        req_valid     = 2'b11;
        req_tid       = {3'd5, 3'd1};
        mem_req_ready = 1'b1;
        #1;
        check_eq("rr0_ready", 128'(req_ready), 128'(2'b01));
        check_eq("rr0_tid", 128'(mem_req_tid), 128'(0));
        check_eq("rr0_data", 128'(mem_req_data), 128'(D0));
        tick();
        check_eq("rr1_ready", 128'(req_ready), 128'(2'b10));
        check_eq("rr1_tid", 128'(mem_req_tid), 128'(1));
        check_eq("rr1_data", 128'(mem_req_data), 128'(D1));
        tick();
        check_eq("rr2_ready", 128'(req_ready), 128'(2'b01));
        check_eq("rr2_tid", 128'(mem_req_tid), 128'(2));
        tick();
        req_valid = '0;
        #1;
        check_eq("busy_outstanding", 128'(busy), 128'(1));

        // Responses route back to owners with their local TIDs.
        mem_rsp_valid = 1'b1;
        mem_rsp_tid   = 4'd1;
        mem_rsp_data  = DA;
        #1;
        check_eq("rsp1_valid", 128'(rsp_valid), 128'(2'b10));
        check_eq("rsp1_tid", 128'(rsp_tid), 128'(5));
        check_eq("rsp1_data", 128'(rsp_data), 128'(DA));
        check_eq("rsp1_spur", 128'(spurious), 128'(0));
        tick();
        mem_rsp_tid = 4'd0;
        #1;
        check_eq("rsp0_valid", 128'(rsp_valid), 128'(2'b01));
        check_eq("rsp0_tid", 128'(rsp_tid), 128'(1));
        tick();
        mem_rsp_tid = 4'd2;
        #1;
        check_eq("rsp2_valid", 128'(rsp_valid), 128'(2'b01));
        check_eq("busy_before_last_free", 128'(busy), 128'(1));
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check_eq("busy_fall", 128'(busy), 128'(0));

        // Fill the pool from port 0, then stall on the 17th request.
        req_valid = 2'b01;
        req_tid   = {3'd5, 3'd1};
        for (int i = 0; i < int'(PoolSize); i++) begin
            #1;
            check_eq("fill_tid", 128'(mem_req_tid), 128'(i));
            check_eq("fill_ready", 128'(req_ready), 128'(2'b01));
            tick();
        end
        #1;
        check_eq("full_ready", 128'(req_ready), 128'(0));
        check_eq("full_valid", 128'(mem_req_valid), 128'(0));
        check_eq("full_busy", 128'(busy), 128'(1));
        mem_rsp_valid = 1'b1;
        mem_rsp_tid   = 4'd7;
        #1;
        check_eq("free7_rsp", 128'(rsp_valid), 128'(2'b01));
        check_eq("free7_no_reuse", 128'(mem_req_valid), 128'(0));
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check_eq("reuse7_tid", 128'(mem_req_tid), 128'(7));
        check_eq("reuse7_ready", 128'(req_ready), 128'(2'b01));
        tick();
        req_valid     = '0;
        mem_rsp_valid = 1'b1;
        for (int i = 0; i < int'(PoolSize); i++) begin
            mem_rsp_tid = MemTidWidth'(i);
            tick();
        end
        mem_rsp_valid = 1'b0;
        #1;
        check_eq("drain_busy", 128'(busy), 128'(0));

        // Stalled grant to port 0 holds while port 1 (next in rr order) also asks.
        mem_req_ready = 1'b0;
        req_valid     = 2'b01;
        req_tid       = {3'd3, 3'd2};
        #1;
        check_eq("lock_c1_valid", 128'(mem_req_valid), 128'(1));
        check_eq("lock_c1_tid", 128'(mem_req_tid), 128'(0));
        check_eq("lock_c1_ready", 128'(req_ready), 128'(0));
        tick();
        req_valid = 2'b11;
        for (int c = 2; c <= 3; c++) begin
            #1;
            check_eq("lock_data", 128'(mem_req_data), 128'(D0));
            check_eq("lock_tid", 128'(mem_req_tid), 128'(0));
            check_eq("lock_ready", 128'(req_ready), 128'(0));
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        check_eq("lock_c4_ready", 128'(req_ready), 128'(2'b01));
        check_eq("lock_c4_tid", 128'(mem_req_tid), 128'(0));
        tick();
        check_eq("after_lock_ready", 128'(req_ready), 128'(2'b10));
        check_eq("after_lock_tid", 128'(mem_req_tid), 128'(1));
        tick();
        req_valid = '0;

        // Response to a never-allocated TID.
        mem_rsp_valid = 1'b1;
        mem_rsp_tid   = 4'd9;
        #1;
        check_eq("spur9_flag", 128'(spurious), 128'(1));
        check_eq("spur9_rsp", 128'(rsp_valid), 128'(0));
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check_eq("spur9_pulse_end", 128'(spurious), 128'(0));

        // Two more outstanding (TIDs 2 and 3), then reset mid-operation.
        req_valid = 2'b01;
        tick();
        tick();
        req_valid = '0;
        #1;
        check_eq("pre_rst_busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_tid   = 4'd2;
        #1;
        check_eq("post_rst_spur", 128'(spurious), 128'(1));
        check_eq("post_rst_rsp", 128'(rsp_valid), 128'(0));
        tick();
        mem_rsp_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
